// File: rtl/ram_loader_if.sv
// Byte-stream input and RAM port B write bundle for ram_loader.
// The loader takes the slave modport; the source or bench takes the master modport.
interface ram_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        wr_en_b;
    logic [31:0] address_b;
    logic [7:0]  data_b;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, wr_en_b, address_b, data_b
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, wr_en_b, address_b, data_b
    );
endinterface

// File: rtl/ram_loader.sv
// Boot loader: streams bytes into RAM port B from address 0 and holds the core in reset until done.
// Optional macro LOADER_CHECKSUM_EN builds the mod-256 byte-sum register.
module ram_loader #(
    parameter int DEPTH       = 256,
    parameter int HOLD_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    ram_loader_if.slave  bus,
    input  logic         reload_i,
    output logic         cpu_rst_o,
    output logic         done_o,
    output logic         full_o,
    output logic [31:0]  byte_count_o,
    output logic [7:0]   checksum_o
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [31:0]   count_q, count_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          full_q, full_d;
    logic          wr_en_q, wr_en_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          accept;

    assign accept = bus.in_valid && (state_q == LOAD);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        hold_d  = hold_q;
        full_d  = full_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    wr_en_d = 1'b1;
                    addr_d  = 32'(ptr_q);
                    data_d  = bus.in_data;
                    ptr_d   = ptr_q + PW'(1);
                    count_d = count_q + 32'd1;
                    if (bus.in_last || ptr_q == PW'(DEPTH - 1)) begin
                        state_d = HOLD;
                        hold_d  = '0;
                        full_d  = !bus.in_last;
                    end
                end
            end
            HOLD: begin
                // Release lands HOLD_CYCLES+1 edges after the final accept.
                if (hold_q == HW'(HOLD_CYCLES)) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            RUN: begin
                if (reload_i) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            count_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = sum_q + bus.in_data;
        end else if (state_q == RUN && reload_i) begin
            sum_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum_o = sum_q;
`else
    assign checksum_o = 8'h00;
`endif

    // Handshake and core control are pure state decodes so reset acts on them immediately.
    assign bus.in_ready  = (state_q == LOAD);
    assign bus.wr_en_b   = wr_en_q;
    assign bus.address_b = addr_q;
    assign bus.data_b    = data_q;
    assign cpu_rst_o     = (state_q != RUN);
    assign done_o        = (state_q == RUN);
    assign full_o        = full_q;
    assign byte_count_o  = count_q;
endmodule
